// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues imem reads from the PC counter, buffers responses
// in a DEPTH-entry FIFO, and flushes on redirect. Define FETCH_CTRL_BYPASS_EN for same-cycle bypass.
module fetch_ctrl #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PC_WIDTH-1:0]    pc,
    output logic                   pc_override,
    output logic [PC_WIDTH-1:0]    pc_in,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count;
    logic                   inflight;
    logic [PC_WIDTH-1:0]    tag_pc;
    logic [PC_WIDTH-1:0]    mem_pc    [DEPTH];
    logic [INSTR_WIDTH-1:0] mem_instr [DEPTH];

    logic           issue;
    logic           push;
    logic           pop;
    logic           bypass_take;
    logic           fifo_wr;
    logic           fifo_rd;
    logic           not_empty;
    logic [CNT_W:0] occupancy;

    always_comb begin
        not_empty = (count != '0);
        occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
        // Reset gates issue so the strobe stays low while rst is held.
        issue     = rst && !redirect_valid && (occupancy < DEPTH_C);
        push      = inflight && !redirect_valid;
`ifdef FETCH_CTRL_BYPASS_EN
        out_valid   = not_empty || push;
        out_pc      = not_empty ? mem_pc[rd_ptr]    : tag_pc;
        out_instr   = not_empty ? mem_instr[rd_ptr] : imem_rdata;
        bypass_take = push && !not_empty && out_ready;
`else
        out_valid   = not_empty;
        out_pc      = mem_pc[rd_ptr];
        out_instr   = mem_instr[rd_ptr];
        bypass_take = 1'b0;
`endif
        pop         = out_valid && out_ready && !redirect_valid;
        fifo_wr     = push && !bypass_take;
        fifo_rd     = pop && not_empty;
        imem_req    = issue;
        imem_addr   = pc;
        pc_override = redirect_valid || !issue;
        pc_in       = redirect_valid ? redirect_pc : pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
            tag_pc   <= '0;
        end else begin
            inflight <= issue;
            tag_pc   <= pc;
            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
                if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
                case ({fifo_wr, fifo_rd})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_pc[wr_ptr]    <= tag_pc;
            mem_instr[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a queue-based model of outstanding fetches checked every cycle,
// plus directed scenarios (stream, backpressure, redirect, flush, async reset, wrap).
module tb_fetch_ctrl;

    localparam int DEPTH = 4;
`ifdef FETCH_CTRL_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic [31:0] addr;
        int          vis;
    } fetch_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic        pc_override;
    logic [31:0] pc_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          first_issue = -1;
    int          first_valid = -1;
    bit          lat_armed = 1'b0;
    fetch_t      mq[$];
    logic [31:0] acc_log[$];
    logic [31:0] p_hold;

    fetch_ctrl #(.PC_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_override(pc_override), .pc_in(pc_in),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_f(logic [31:0] a);
        return (a ^ 32'hC0DE_0000) + 32'h11;
    endfunction

    // PC counter and one-cycle instruction memory
    always @(posedge clk) begin
        pc         <= pc_override ? pc_in : pc + 32'd1;
        imem_rdata <= imem_req ? imem_f(imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_log(string name, int idx, logic [31:0] exp);
        if (idx < acc_log.size()) chk(name, {32'd0, acc_log[idx]}, {32'd0, exp});
        else begin
            vectors++;
            miscompares++;
            $display("FAIL %s: entry %0d missing, expected %0h", name, idx, exp);
        end
    endtask

    // Model: mq holds every issued-but-not-consumed fetch with the cycle it becomes visible.
    task automatic model_cycle();
        logic   exp_issue;
        logic   exp_valid;
        fetch_t e;
        if (!rst) begin
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_imem_req", {63'd0, imem_req}, 64'd0);
            chk("rst_pc_override", {63'd0, pc_override}, 64'd1);
            chk("rst_pc_in", {32'd0, pc_in}, {32'd0, pc});
            mq.delete();
        end else begin
            exp_issue = !redirect_valid && (mq.size() < DEPTH);
            exp_valid = (mq.size() > 0) && (mq[0].vis <= cyc);
            chk("imem_req", {63'd0, imem_req}, {63'd0, exp_issue});
            if (exp_issue) chk("imem_addr", {32'd0, imem_addr}, {32'd0, pc});
            chk("pc_override", {63'd0, pc_override}, {63'd0, redirect_valid || !exp_issue});
            chk("pc_in", {32'd0, pc_in}, {32'd0, redirect_valid ? redirect_pc : pc});
            if (!redirect_valid) begin
                chk("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
                if (exp_valid) begin
                    chk("out_pc", {32'd0, out_pc}, {32'd0, mq[0].addr});
                    chk("out_instr", {32'd0, out_instr}, {32'd0, imem_f(mq[0].addr)});
                end
            end
            if (out_valid && out_ready && !redirect_valid) acc_log.push_back(out_pc);
            if (lat_armed) begin
                if (first_issue < 0 && imem_req) first_issue = cyc;
                if (first_valid < 0 && out_valid) first_valid = cyc;
            end
            if (redirect_valid) mq.delete();
            else begin
                if (exp_valid && out_ready) void'(mq.pop_front());
                if (exp_issue) begin
                    e.addr = pc;
                    e.vis  = cyc + LAT;
                    mq.push_back(e);
                end
            end
        end
        cyc++;
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            model_cycle();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_imem_req", {63'd0, imem_req}, 64'd0);
        chk("reset_pc_override", {63'd0, pc_override}, 64'd1);
        step(2);

        // Streaming from pc=0
        rst = 1'b1;
        lat_armed = 1'b1;
        acc_log.delete();
        step(8);
        lat_armed = 1'b0;
        chk("stream_latency", 64'(first_valid - first_issue), 64'(LAT));
        chk_log("stream_pc0", 0, 32'h0);
        chk_log("stream_pc1", 1, 32'h1);
        chk_log("stream_pc2", 2, 32'h2);

        // Backpressure: four entries fill the buffer, then the PC is held
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        out_ready = 1'b0;
        step(1);
        redirect_valid = 1'b0;
        step(8);
        #1;
        chk("bp_pc_held", {32'd0, pc}, 64'h104);
        chk("bp_imem_req", {63'd0, imem_req}, 64'd0);
        chk("bp_pc_override", {63'd0, pc_override}, 64'd1);
        chk("bp_pc_in", {32'd0, pc_in}, 64'h104);
        chk("bp_out_pc", {32'd0, out_pc}, 64'h100);
        acc_log.delete();
        out_ready = 1'b1;
        step(12);
        for (int i = 0; i < 10; i++) chk_log("bp_order", i, 32'h100 + 32'(i));

        // Redirect with three buffered and one in flight
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        out_ready = 1'b0;
        step(1);
        redirect_valid = 1'b0;
        step(4);
        chk("rd_pre_imem_req", {63'd0, imem_req}, 64'd0);
        chk("rd_pre_out_pc", {32'd0, out_pc}, 64'h200);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        acc_log.delete();
        #1;
        chk("rd_pc_override", {63'd0, pc_override}, 64'd1);
        chk("rd_pc_in", {32'd0, pc_in}, 64'h40);
        chk("rd_imem_req", {63'd0, imem_req}, 64'd0);
        step(1);
        redirect_valid = 1'b0;
        #1;
        chk("rd_next_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rd_next_imem_addr", {32'd0, imem_addr}, 64'h40);
        out_ready = 1'b1;
        step(4);
        chk_log("rd_first_pc", 0, 32'h40);
        chk_log("rd_second_pc", 1, 32'h41);

        // Redirect against a full buffer with out_ready=1
        out_ready = 1'b0;
        step(8);
        chk("full_out_valid", {63'd0, out_valid}, 64'd1);
        chk("full_imem_req", {63'd0, imem_req}, 64'd0);
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        acc_log.delete();
        step(1);
        redirect_valid = 1'b0;
        #1;
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        step(4);
        chk_log("flush_first_pc", 0, 32'h300);

        // Asynchronous reset between edges mid-stream
        step(5);
        #1;
        rst = 1'b0;
        #1;
        chk("areset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("areset_imem_req", {63'd0, imem_req}, 64'd0);
        acc_log.delete();
        step(2);
        p_hold = pc;
        rst = 1'b1;
        step(6);
        chk_log("areset_first_pc", 0, p_hold);
        chk_log("areset_second_pc", 1, p_hold + 32'd1);

        // Pointer wrap under random backpressure
        redirect_valid = 1'b1;
        redirect_pc = 32'h600;
        acc_log.delete();
        step(1);
        redirect_valid = 1'b0;
        repeat (40) begin
            out_ready = 1'($urandom_range(0, 1));
            step(1);
        end
        out_ready = 1'b1;
        step(10);
        chk("wrap_enough", {63'd0, acc_log.size() >= 3 * DEPTH}, 64'd1);
        for (int i = 0; i < acc_log.size(); i++) chk_log("wrap_order", i, 32'h600 + 32'(i));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32: width of all PC values.
REQ-002 SHALL have parameter INSTR_WIDTH, default 32: instruction word width.
REQ-003 SHALL have parameter DEPTH, default 4: fetch buffer entries, power of two, >=2.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pc  input  PC_WIDTH  current PC from the PC counter.
REQ-007 SHALL have port pc_override  output  1  forces the PC counter to load pc_in next edge.
REQ-008 SHALL have port pc_in  output  PC_WIDTH  value loaded by PC counter when pc_override=1.
REQ-009 SHALL have port imem_req  output  1  instruction memory read strobe.
REQ-010 SHALL have port imem_addr  output  PC_WIDTH  read address.
REQ-011 SHALL have port imem_rdata  input  INSTR_WIDTH  read data, valid exactly one cycle after imem_req.
REQ-012 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-013 SHALL have port redirect_pc  input  PC_WIDTH  redirect target.
REQ-014 SHALL have port out_valid  output  1  instruction available to decode.
REQ-015 SHALL have port out_ready  input  1  decode accepts instruction.
REQ-016 SHALL have port out_pc  output  PC_WIDTH  PC of presented instruction.
REQ-017 SHALL have port out_instr  output  INSTR_WIDTH  presented instruction.

Function
REQ-018 SHALL compute issue = !redirect_valid && (count + inflight < DEPTH), from registered count/inflight.
REQ-019 SHALL drive imem_req = issue and imem_addr = pc, combinationally.
REQ-020 SHALL drive pc_override = redirect_valid || !issue, combinationally.
REQ-021 SHALL drive pc_in = redirect_pc when redirect_valid, else pc (hold PC while stalled).
REQ-022 SHALL register inflight <= issue and tag_pc <= pc each edge.
REQ-023 SHALL, when inflight=1 and no redirect, write {tag_pc, imem_rdata} into the FIFO tail that cycle.
REQ-024 SHALL present FIFO head on out_pc/out_instr with out_valid = (count != 0).
REQ-025 SHALL pop the head on out_valid && out_ready; push and pop in the same cycle leave count unchanged.
REQ-026 SHALL wrap read/write pointers modulo DEPTH; count range 0..DEPTH, never overflow or underflow.
REQ-027 SHALL, on redirect_valid, clear count and pointers, drop the inflight response, and issue nothing that cycle; first target fetch is issued the following cycle.
REQ-028 SHALL give redirect priority over stall, push and pop in the same cycle; out_valid may still be 1 that cycle but the pop SHALL be ignored by flush.
REQ-029 SHALL deliver, without bypass, an instruction issued in cycle N with out_valid in cycle N+2.
REQ-030 SHALL preserve program order: out_pc sequence equals issued address sequence since last redirect.

Reset
REQ-031 SHALL, while rst=0, clear count, pointers, inflight and tag_pc (to 0) asynchronously.
REQ-032 SHALL hold out_valid=0 and imem_req=0 during reset; pc_override/pc_in follow REQ-020/021.
REQ-033 SHALL treat reset mid-operation as full flush; no pre-reset instruction SHALL appear afterwards.

Configuration
REQ-034 SHALL support macro FETCH_CTRL_BYPASS_EN.
REQ-035 SHALL, with FETCH_CTRL_BYPASS_EN defined, when count=0 and a response arrives, present it same cycle (out_valid=1, N+1 latency); if out_ready=1 it SHALL not be written to the FIFO.
REQ-036 SHALL, without FETCH_CTRL_BYPASS_EN, always write responses to the FIFO (latency N+2).

Verification
REQ-037 SHALL test streaming: pc=0x0,0x1,0x2..., out_ready=1 -> out_pc 0x0,0x1,0x2 consecutive, first out_valid cycle 2 after first issue (1 with bypass).
REQ-038 SHALL test backpressure: out_ready=0, DEPTH=4 -> exactly 4 entries buffered, then imem_req=0, pc_override=1, pc_in=pc; release -> order intact, no loss/duplication.
REQ-039 SHALL test redirect: redirect_valid=1, redirect_pc=0x40 with 3 entries buffered and one inflight -> out_valid=0 next cycle, pc_override=1, pc_in=0x40; next out_pc=0x40.
REQ-040 SHALL test redirect coinciding with full FIFO and out_ready=1 -> flush wins, count=0.
REQ-041 SHALL test async reset asserted mid-stream between edges -> out_valid=0 immediately; after release first out_pc equals pc presented at first issue.
REQ-042 SHALL test pointer wrap: 3*DEPTH instructions through with random out_ready -> in-order, no gaps.
